// File: rtl/cdc_req_ack_tx.sv
// Source side of a 4-phase req/ack crossing: captures a word, raises xfer_req,
// and sequences req-up/ack-up/req-down/ack-down using a synchronized xfer_ack.
module cdc_req_ack_tx #(
    parameter int W              = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [W-1:0]     src_data,
    output logic             xfer_req,
    output logic [W-1:0]     xfer_data,
    input  logic             xfer_ack,
    output logic             done,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             err,
    input  logic             err_clr
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [TW-1:0]          tmr;
    logic                   waiting;
    logic                   tmr_hit;

    // xfer_ack is asynchronous to clk; only the last stage of this chain is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], xfer_ack};
        end
    end

    assign ack_s     = ack_sync[SYNC_STAGES-1];
    assign src_ready = (state == IDLE) && !ack_s;

    // A phase is still waiting when the FSM stays in REQ or ACK this cycle.
    assign waiting = ((state == REQ) && !ack_s) || ((state == ACK) && ack_s);
    assign tmr_hit = (TIMEOUT_CYCLES != 0) && waiting && (tmr == TMAX - TW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            xfer_req  <= 1'b0;
            xfer_data <= '0;
            done      <= 1'b0;
            xfer_cnt  <= '0;
            tmr       <= '0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (src_valid && src_ready) begin
                        xfer_data <= src_data;
                        xfer_req  <= 1'b1;
                        state     <= REQ;
                        tmr       <= '0;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        xfer_req <= 1'b0;
                        state    <= ACK;
                        tmr      <= '0;
                    end else if (tmr != TMAX) begin
                        tmr <= tmr + TW'(1);
                    end
                end
                ACK: begin
                    if (!ack_s) begin
                        state    <= IDLE;
                        done     <= 1'b1;
                        xfer_cnt <= xfer_cnt + CNT_W'(1);
                        tmr      <= '0;
                    end else if (tmr != TMAX) begin
                        tmr <= tmr + TW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    xfer_req <= 1'b0;
                    tmr      <= '0;
                end
            endcase

            // A timeout hit in the same cycle as err_clr keeps err set.
            if (tmr_hit) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdc_req_ack_tx.sv
// Bench for cdc_req_ack_tx: the bench plays the destination side and scoreboards
// captured words, handshake timing, completion counts and the timeout flag.
module tb_cdc_req_ack_tx;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int TO = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [W-1:0]  src_data = '0;
    logic          xfer_req;
    logic [W-1:0]  xfer_data;
    logic          xfer_ack = 1'b0;
    logic          done;
    logic [CW-1:0] xfer_cnt;
    logic          err;
    logic          err_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    cdc_req_ack_tx #(
        .W(W),
        .SYNC_STAGES(SS),
        .TIMEOUT_CYCLES(TO),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .src_data(src_data),
        .xfer_req(xfer_req),
        .xfer_data(xfer_data),
        .xfer_ack(xfer_ack),
        .done(done),
        .xfer_cnt(xfer_cnt),
        .err(err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        src_valid = 1'b0;
        err_clr = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic test_reset();
        xfer_ack = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({xfer_req, done, err, xfer_data, xfer_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b done=%b err=%b data=%h cnt=%h exp all 0",
                     xfer_req, done, err, xfer_data, xfer_cnt);
        end
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (src_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_after_release got=%b exp=1", src_ready);
        end
        src_valid = 1'b1;
        src_data = 8'h3C;
        @(posedge clk);
        #1 src_valid = 1'b0;
        checks++;
        if (xfer_req !== 1'b1 || xfer_data !== 8'h3C) begin
            failures++;
            $display("FAIL reset_pre_capture got req=%b data=%h exp req=1 data=3c", xfer_req, xfer_data);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (xfer_req !== 1'b0 || xfer_data !== 8'h00 || src_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_handshake got req=%b data=%h ready=%b exp req=0 data=00 ready=1",
                     xfer_req, xfer_data, src_ready);
        end
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        logic [W-1:0] e;
        apply_reset();
        exp_q.delete();
        xfer_ack = 1'b0;
        @(posedge clk);
        #1 src_valid = 1'b1;
        src_data = 8'hA5;
        @(negedge clk);
        checks++;
        if (xfer_req !== 1'b0) begin
            failures++;
            $display("FAIL single_req_before_capture got=%b exp=0", xfer_req);
        end
        if (src_valid && src_ready) exp_q.push_back(src_data);
        @(posedge clk);
        #1 src_valid = 1'b0;
        src_data = '0;
        @(negedge clk);
        checks++;
        if (xfer_req !== 1'b1 || src_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_req_rise got req=%b ready=%b exp req=1 ready=0", xfer_req, src_ready);
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL single_scoreboard_empty got=0 entries exp=1");
        end else begin
            e = exp_q.pop_front();
            if (xfer_data !== e) begin
                failures++;
                $display("FAIL single_data got=%h exp=%h", xfer_data, e);
            end
        end
        xfer_ack = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            checks++;
            if (xfer_data !== 8'hA5) begin
                failures++;
                $display("FAIL single_data_hold got=%h exp=a5", xfer_data);
            end
        end while (xfer_req && n < 10);
        checks++;
        if (n !== SS + 1) begin
            failures++;
            $display("FAIL single_req_fall_edges got=%0d exp=%0d", n, SS + 1);
        end
        @(negedge clk);
        xfer_ack = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 10);
        checks++;
        if (n !== SS + 1 || done !== 1'b1) begin
            failures++;
            $display("FAIL single_done_edges got=%0d done=%b exp=%0d done=1", n, done, SS + 1);
        end
        checks++;
        if (xfer_cnt !== 2'd1 || xfer_data !== 8'hA5) begin
            failures++;
            $display("FAIL single_cnt_data got cnt=%0d data=%h exp cnt=1 data=a5", xfer_cnt, xfer_data);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || src_ready !== 1'b1 || xfer_cnt !== 2'd1) begin
            failures++;
            $display("FAIL single_after_done got done=%b ready=%b cnt=%0d exp done=0 ready=1 cnt=1",
                     done, src_ready, xfer_cnt);
        end
    endtask

    task automatic test_back_to_back(input int n, input logic [W-1:0] base);
        int sent, got, cyc;
        logic prev_req, acc;
        logic [W-1:0] e;
        logic [CW-1:0] exp_cnt;
        apply_reset();
        exp_q.delete();
        xfer_ack = 1'b0;
        sent = 0;
        got = 0;
        cyc = 0;
        prev_req = 1'b0;
        exp_cnt = '0;
        @(posedge clk);
        #1 src_valid = 1'b1;
        src_data = base;
        while (got < n && cyc < 400) begin
            @(negedge clk);
            if (xfer_req && !prev_req) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected_req got data=%h exp none", xfer_data);
                end else begin
                    e = exp_q.pop_front();
                    if (xfer_data !== e) begin
                        failures++;
                        $display("FAIL b2b_data got=%h exp=%h", xfer_data, e);
                    end
                end
            end
            checks++;
            if (src_ready && xfer_req) begin
                failures++;
                $display("FAIL b2b_ready_while_req got ready=1 req=1 exp ready=0");
            end
            if (done) begin
                got++;
                exp_cnt = exp_cnt + CW'(1);
                checks++;
                if (xfer_cnt !== exp_cnt) begin
                    failures++;
                    $display("FAIL b2b_count got=%0d exp=%0d", xfer_cnt, exp_cnt);
                end
            end
            prev_req = xfer_req;
            xfer_ack = xfer_req;
            acc = src_valid && src_ready;
            if (acc) exp_q.push_back(src_data);
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                if (sent < n) src_data = base + W'(sent);
                else src_valid = 1'b0;
            end
            cyc++;
        end
        xfer_ack = 1'b0;
        checks++;
        if (got !== n || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_completion got=%0d left=%0d exp=%0d left=0", got, exp_q.size(), n);
        end
    endtask

    task automatic test_wrap();
        test_back_to_back(5, 8'h10);
        checks++;
        if (xfer_cnt !== 2'd1) begin
            failures++;
            $display("FAIL wrap_final_count got=%0d exp=1", xfer_cnt);
        end
    endtask

    task automatic test_stale_ack();
        int n;
        logic [W-1:0] e;
        exp_q.delete();
        xfer_ack = 1'b1;
        apply_reset();
        repeat (SS) @(posedge clk);
        #1 src_valid = 1'b1;
        src_data = 8'h5C;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (src_ready !== 1'b0 || xfer_req !== 1'b0) begin
                failures++;
                $display("FAIL stale_hold got ready=%b req=%b exp ready=0 req=0", src_ready, xfer_req);
            end
        end
        xfer_ack = 1'b0;
        n = 0;
        while (!xfer_req && n < 10) begin
            if (src_valid && src_ready) exp_q.push_back(src_data);
            @(negedge clk);
            n++;
        end
        src_valid = 1'b0;
        checks++;
        if (n !== SS + 1) begin
            failures++;
            $display("FAIL stale_capture_edges got=%0d exp=%0d", n, SS + 1);
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL stale_scoreboard_empty got=0 entries exp=1");
        end else begin
            e = exp_q.pop_front();
            if (xfer_data !== e || xfer_cnt !== 2'd0) begin
                failures++;
                $display("FAIL stale_data got data=%h cnt=%0d exp data=%h cnt=0", xfer_data, xfer_cnt, e);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        apply_reset();
        xfer_ack = 1'b0;
        @(posedge clk);
        #1 src_valid = 1'b1;
        src_data = 8'hE7;
        @(posedge clk);
        #1 src_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!err && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== TO || xfer_req !== 1'b1) begin
            failures++;
            $display("FAIL timeout_latency got=%0d req=%b exp=%0d req=1", n, xfer_req, TO);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err !== 1'b1 || xfer_req !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got err=%b req=%b exp err=1 req=1", err, xfer_req);
        end
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear got=%b exp=0", err);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (err !== 1'b0 || xfer_req !== 1'b1) begin
            failures++;
            $display("FAIL timeout_no_reset got err=%b req=%b exp err=0 req=1", err, xfer_req);
        end
        xfer_ack = 1'b1;
        n = 0;
        while (xfer_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        xfer_ack = 1'b0;
        n = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1 || xfer_cnt !== 2'd1 || err !== 1'b0 || xfer_data !== 8'hE7) begin
            failures++;
            $display("FAIL timeout_completion got done=%b cnt=%0d err=%b data=%h exp done=1 cnt=1 err=0 data=e7",
                     done, xfer_cnt, err, xfer_data);
        end
    endtask

    task automatic test_err_set_wins();
        int n;
        apply_reset();
        xfer_ack = 1'b0;
        @(posedge clk);
        #1 src_valid = 1'b1;
        src_data = 8'h81;
        err_clr = 1'b1;
        @(posedge clk);
        #1 src_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!err && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== TO || err !== 1'b1) begin
            failures++;
            $display("FAIL set_wins_over_clear got=%0d err=%b exp=%0d err=1", n, err, TO);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL set_wins_then_clear got=%b exp=0", err);
        end
        err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back(3, 8'h01);
        checks++;
        if (xfer_cnt !== 2'd3) begin
            failures++;
            $display("FAIL b2b_final_count got=%0d exp=3", xfer_cnt);
        end
        test_stale_ack();
        test_timeout();
        test_err_set_wins();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdc_req_ack_tx.md
Name: cdc_req_ack_tx

Overview:
- Source-domain controller for a 4-phase req/ack handshake carrying a W-bit word into another clock domain.
- Accepts a word over a valid/ready interface, holds it stable on xfer_data, and drives xfer_req.
- Synchronizes the returning xfer_ack through an internal flop chain and sequences the full req-up/ack-up/req-down/ack-down cycle.
- Adds a completed-transfer counter and a sticky handshake-timeout flag for debug.

Parameters:
- W, 8, payload width in bits.
- SYNC_STAGES, 2, flops in the xfer_ack synchronizer chain; legal range 2..4.
- TIMEOUT_CYCLES, 1024, cycles a phase may wait for ack before err is set; 0 disables the timeout.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  source-domain clock; every flop is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- src_valid  input  1  source has a word on src_data.
- src_ready  output  1  block can accept a word this cycle.
- src_data  input  W  word to transfer.
- xfer_req  output  1  handshake request to the destination domain; registered, glitch-free.
- xfer_data  output  W  payload; registered; stable whenever xfer_req=1.
- xfer_ack  input  1  handshake acknowledge from the destination domain; asynchronous to clk.
- done  output  1  one-cycle pulse when a handshake completes.
- xfer_cnt  output  CNT_W  number of completed handshakes; wraps.
- err  output  1  sticky timeout flag.
- err_clr  input  1  clears err.

Behaviour:
- Reset:
  - rst high clears the ack sync chain (ack_s=0), state=IDLE, xfer_req=0, xfer_data=0, done=0, xfer_cnt=0, err=0 and the timeout counter.
  - Reset takes effect immediately, not at the next edge.
  - Reset mid-handshake drops xfer_req asynchronously; the destination side treats a req fall as a normal phase end.
- ack_s is xfer_ack delayed through SYNC_STAGES flops. The FSM uses only ack_s, never raw xfer_ack.
- src_ready = (state==IDLE) && !ack_s. This is combinational from registers only and never depends on src_valid.
- FSM states and transitions:
  - IDLE: on src_valid && src_ready, load xfer_data<=src_data and go to REQ. xfer_req=1 from the next cycle.
  - REQ: xfer_req=1. When ack_s==1, go to ACK and set xfer_req=0.
  - ACK: xfer_req=0. When ack_s==0, go to IDLE, pulse done for 1 cycle, and set xfer_cnt<=xfer_cnt+1 (mod 2^CNT_W).
- Timing:
  - xfer_req falls on the (SYNC_STAGES+1)-th rising edge after xfer_ack rises, with xfer_ack changing between edges.
  - IDLE is re-entered on the (SYNC_STAGES+1)-th edge after xfer_ack falls.
  - Minimum accept-to-accept interval with a zero-delay destination is 2*(SYNC_STAGES+1)+1 cycles.
- xfer_data changes only at the IDLE->REQ capture. It holds its value in IDLE after completion.
- ack_s=1 while in IDLE (stale ack after reset or a destination fault): stay in IDLE with src_ready=0 until ack_s=0. No state or count change.
- Timeout:
  - A saturating counter of width $clog2(TIMEOUT_CYCLES+1) increments each cycle in REQ or ACK and clears on every state change.
  - When it reaches TIMEOUT_CYCLES, err<=1.
  - The FSM keeps waiting; the handshake is never aborted.
  - With TIMEOUT_CYCLES=0, err never sets.
- err_clr=1 clears err next cycle. If a timeout hit and err_clr occur in the same cycle, set wins and err stays 1.
- done and the xfer_cnt increment occur in the same cycle.

Test Plan:
- Reset: assert rst mid-cycle with xfer_ack=0 -> all outputs 0 immediately. After release, src_ready=1 on the first edge.
- Single transfer: src_data=0xA5, src_valid=1 at edge 0; bench raises xfer_ack 1 cycle after seeing xfer_req and drops it 1 cycle after req falls (SYNC_STAGES=2) -> required response:
  - xfer_req=1 from edge 1.
  - xfer_data=0xA5 held throughout.
  - xfer_req falls 3 edges after the ack rise.
  - done pulses once, 3 edges after the ack fall.
  - xfer_cnt=1.
- Back-to-back: src_valid held with 0x01, 0x02, 0x03 -> each word is accepted only when src_ready=1, each appears on xfer_data in order, xfer_cnt=3, and src_ready is never 1 while xfer_req=1.
- Stale ack: hold xfer_ack=1 through the reset release with src_valid=1 -> src_ready stays 0 and no capture occurs. Drop ack -> capture occurs SYNC_STAGES+1 edges later.
- Timeout: TIMEOUT_CYCLES=8, ack never returns -> err=1 exactly 8 cycles after REQ entry and xfer_req stays 1. Then pulse err_clr -> err returns to 0 next cycle, because the saturated counter does not re-set it; the handshake still completes once ack arrives.
- Wrap: CNT_W=2, run 5 transfers -> xfer_cnt sequence 1,2,3,0,1.
